cga_bus_regs: RTL and testbench
===============================

# cga_bus_regs

Parametrised ISA-side register and bus-timing block for the CGA/Tandy video adapter. It contains the I/O address decode, bus-line synchroniser and write-pulse generator. It holds the mode control, colour select and Tandy page registers, the status register, the CRTC chip-select/strobe generation, the VRAM wait-state generator and frame-locked cursor/character blink. It sits between the ISA bus pins and the crtc6845, sequencer and pixel blocks, and replaces the ad-hoc decode and blink logic in the adapter top level.

## Interface
- IO_BASE_ADDR, 16'h3D0, I/O base address; 3D0 selects CGA, 3B0 selects MDA. Bits [14:3] are decoded.
- USE_BUS_WAIT, 0, 1 enables the VRAM wait-state generator; 0 ties bus_rdy high.
- WAIT_START_SLOT, 5'd17, sequencer slot that ends wait phase A.
- WAIT_END_SLOT, 5'd20, sequencer slot that ends wait phase B.
- CURSOR_FRAMES, 8, frames per cursor_blink toggle (≥1).
- CHAR_FRAMES, 16, frames per char_blink toggle (≥1).
- CTRL_RESET, 8'h28, reset value of control_reg (text mode, 80 columns off, blink on).

Clocking and reset: one clock; reset is synchronous and active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bus_a  in  15  ISA address
- bus_d  in  8  ISA write data
- bus_ior_l, bus_iow_l  in  1  ISA I/O strobes (asynchronous)
- bus_memr_l, bus_memw_l  in  1  ISA memory strobes (asynchronous)
- bus_aen  in  1  DMA address enable; decode is inhibited when high
- bus_mem_sel  in  1  framebuffer window hit, decoded externally
- bus_out  out  8  read data
- bus_dir  out  1  high while this block drives a read
- bus_rdy  out  1  ISA ready
- clk_seq  in  5  sequencer slot counter
- vsync_l, display_enable  in  1  from the CRTC
- crtc_dout  in  8  CRTC register read data
- splashscreen  in  1  freezes blink while high
- crtc_cs  out  1  combinational decode for base+0..7
- crtc_write, crtc_read  out  1  one-cycle strobes
- control_reg, color_reg, page_reg  out  8  register contents
- cursor_blink, char_blink  out  1  blink phases

## Operation
- Address decode (combinational, all terms qualified by ~bus_aen):
  - crtc_cs: bus_a[14:3] == base[14:3]
  - control: base+8
  - colour: base+9
  - status: base+A
  - page: base+F
- Synchroniser: bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, vsync_l and display_enable each pass through two flops.
- Write pulse: generated when synced iow_l goes 1→0. There is exactly one pulse per ISA write cycle, regardless of strobe length.
- On the write pulse, a decoded register captures bus_d.
  - crtc_write pulses for base+0..7; a0 comes directly from bus_a.
- crtc_read pulses once on the synced ior_l falling edge when crtc_cs is true.
- Read mux (combinational on raw bus_ior_l):
  - status hit: bus_out = {4'b1111, vsync_l_s, 2'b10, ~display_enable_s}
  - crtc_cs and bus_a[0]=1: bus_out = crtc_dout
  - otherwise: bus_out = 0
  - bus_dir = (crtc_cs | status hit) & ~bus_ior_l
- Wait FSM, active when USE_BUS_WAIT=1. memsel = bus_mem_sel & (~memr_s | ~memw_s).
  - IDLE (bus_rdy=1): go to WA when memsel.
  - WA (bus_rdy=0): go to WB when clk_seq == WAIT_START_SLOT.
  - WB (bus_rdy=0): go to DONE when clk_seq == WAIT_END_SLOT.
  - DONE (bus_rdy=1): hold until memsel drops, then go to IDLE.
  - memsel dropping in any state returns the FSM to IDLE.
- Blink:
  - A frame tick occurs on the synced vsync_l falling edge.
  - The cursor counter and the character counter (widths $clog2 of their limits) increment on each tick.
  - When a counter reaches its limit minus 1, it wraps to 0 and toggles its output.
  - When splashscreen=1, counters and outputs hold.

## Timing
- Reset values:
  - control_reg = CTRL_RESET; color_reg = 0; page_reg = 0.
  - bus_rdy = 1; FSM = IDLE.
  - Blink counters = 0; cursor_blink = 0; char_blink = 0.
  - Write and read strobes = 0; synchroniser flops = 1.
  - bus_out and bus_dir are combinational and follow the inputs.
- Write latency: with bus_iow_l sampled low at edge 0, the pulse is high in the cycle after edge 2 and the register is updated at edge 3.
- bus_a and bus_d must be stable from the iow_l falling edge through edge 3. ISA timing guarantees this.
- bus_rdy falls no later than 3 edges after the memory strobe falls. It rises at the edge that samples clk_seq == WAIT_END_SLOT while in WB.
- Blink update is registered, one cycle after the tick.
- reset overrides simultaneous writes and ticks. Reset mid-wait forces bus_rdy=1 on the next edge.
- ior and iow low together is illegal: the write still completes, and read data is undefined.

## Test plan
- Reset, then write 8'h1A to 3D8 and 8'h0F to 3D9 → control_reg=1A at edge 3 after the strobe, color_reg=0F; a single pulse per write even with a 20-cycle strobe.
- Read 3DA with vsync_l=0, display_enable=1 → bus_out=8'hF4, bus_dir=1; with vsync_l=1, display_enable=0 → bus_out=8'hFD.
- Write 3D4 then 3D5 → crtc_cs=1, exactly one crtc_write pulse each; read 3D5 with crtc_dout=8'h55 → bus_out=55. Write with bus_aen=1 → no register change.
- USE_BUS_WAIT=1, memr during clk_seq=5 → bus_rdy low until clk_seq passes 17 then 20, then high; drop memr during WA → IDLE, bus_rdy=1.
- 32 vsync pulses → cursor_blink toggles 4 times, char_blink toggles 2 times; with splashscreen=1 for 10 frames → no change.

Source files
------------

// File: rtl/cga_bus_regs.sv
// ---------------------------------------------------------------------------
// cga_bus_regs : ISA decode, synchronisers, adapter registers, wait states
// and frame-locked blink for the CGA/Tandy adapter.    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cga_bus_regs #(
  parameter logic [15:0] IO_BASE_ADDR    = 16'h3D0,
  parameter bit          USE_BUS_WAIT    = 1'b0,
  parameter logic [4:0]  WAIT_START_SLOT = 5'd17,
  parameter logic [4:0]  WAIT_END_SLOT   = 5'd20,
  parameter int          CURSOR_FRAMES   = 8,
  parameter int          CHAR_FRAMES     = 16,
  parameter logic [7:0]  CTRL_RESET      = 8'h28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] bus_a,
  input  logic [7:0]  bus_d,
  input  logic        bus_ior_l,
  input  logic        bus_iow_l,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic        bus_aen,
  input  logic        bus_mem_sel,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        bus_rdy,
  input  logic [4:0]  clk_seq,
  input  logic        vsync_l,
  input  logic        display_enable,
  input  logic [7:0]  crtc_dout,
  input  logic        splashscreen,
  output logic        crtc_cs,
  output logic        crtc_write,
  output logic        crtc_read,
  output logic [7:0]  control_reg,
  output logic [7:0]  color_reg,
  output logic [7:0]  page_reg,
  output logic        cursor_blink,
  output logic        char_blink
);

  localparam logic [14:0] BASE        = {IO_BASE_ADDR[14:3], 3'b000};
  localparam logic [14:0] ADDR_CTRL   = BASE + 15'd8;
  localparam logic [14:0] ADDR_COLOR  = BASE + 15'd9;
  localparam logic [14:0] ADDR_STATUS = BASE + 15'd10;
  localparam logic [14:0] ADDR_PAGE   = BASE + 15'd15;

  localparam int CUR_W = (CURSOR_FRAMES > 1) ? $clog2(CURSOR_FRAMES) : 1;
  localparam int CHR_W = (CHAR_FRAMES > 1) ? $clog2(CHAR_FRAMES) : 1;
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(CURSOR_FRAMES - 1);
  localparam logic [CHR_W-1:0] CHR_LAST = CHR_W'(CHAR_FRAMES - 1);

  // Order: ior, iow, memr, memw, vsync, display_enable
  logic [5:0] sync1, sync2;
  logic [2:0] prev;  // previous synced ior, iow, vsync for edge detection
  logic       ior_s, iow_s, memr_s, memw_s, vsync_s, de_s;
  logic       ior_fall, iow_fall, frame_tick, wr_pulse;
  logic       ctrl_hit, color_hit, status_hit, page_hit, memsel;

  assign {ior_s, iow_s, memr_s, memw_s, vsync_s, de_s} = sync2;
  assign ior_fall   = prev[2] & ~ior_s;
  assign iow_fall   = prev[1] & ~iow_s;
  assign frame_tick = prev[0] & ~vsync_s;

  assign crtc_cs    = ~bus_aen & (bus_a[14:3] == BASE[14:3]);
  assign ctrl_hit   = ~bus_aen & (bus_a == ADDR_CTRL);
  assign color_hit  = ~bus_aen & (bus_a == ADDR_COLOR);
  assign status_hit = ~bus_aen & (bus_a == ADDR_STATUS);
  assign page_hit   = ~bus_aen & (bus_a == ADDR_PAGE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '1;
      sync2       <= '1;
      prev        <= '1;
      wr_pulse    <= 1'b0;
      crtc_write  <= 1'b0;
      crtc_read   <= 1'b0;
      control_reg <= CTRL_RESET;
      color_reg   <= 8'h00;
      page_reg    <= 8'h00;
    end else begin
      sync1      <= {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, vsync_l, display_enable};
      sync2      <= sync1;
      prev       <= {ior_s, iow_s, vsync_s};
      wr_pulse   <= iow_fall;
      crtc_write <= iow_fall & crtc_cs;
      crtc_read  <= ior_fall & crtc_cs;
      if (wr_pulse & ctrl_hit)  control_reg <= bus_d;
      if (wr_pulse & color_hit) color_reg   <= bus_d;
      if (wr_pulse & page_hit)  page_reg    <= bus_d;
    end
  end

  always_comb begin
    bus_out = 8'h00;
    if (~bus_ior_l) begin
      if (status_hit)
        bus_out = {4'b1111, vsync_s, 2'b10, ~de_s};
      else if (crtc_cs & bus_a[0])
        bus_out = crtc_dout;
    end
  end

  assign bus_dir = (crtc_cs | status_hit) & ~bus_ior_l;

  // Wait-state FSM; when disabled its output is simply ignored.
  typedef enum logic [1:0] {W_IDLE, W_A, W_B, W_DONE} wait_t;
  wait_t wstate;
  logic  rdy_q;

  assign memsel  = bus_mem_sel & (~memr_s | ~memw_s);
  assign bus_rdy = USE_BUS_WAIT ? rdy_q : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate <= W_IDLE;
      rdy_q  <= 1'b1;
    end else if (!memsel) begin
      wstate <= W_IDLE;
      rdy_q  <= 1'b1;
    end else begin
      case (wstate)
        W_IDLE: begin
          wstate <= W_A;
          rdy_q  <= 1'b0;
        end
        W_A:
          if (clk_seq == WAIT_START_SLOT) wstate <= W_B;
        W_B:
          if (clk_seq == WAIT_END_SLOT) begin
            wstate <= W_DONE;
            rdy_q  <= 1'b1;
          end
        default: wstate <= W_DONE;
      endcase
    end
  end

  logic [CUR_W-1:0] cur_cnt;
  logic [CHR_W-1:0] chr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_cnt      <= '0;
      chr_cnt      <= '0;
      cursor_blink <= 1'b0;
      char_blink   <= 1'b0;
    end else if (frame_tick & ~splashscreen) begin
      if (cur_cnt == CUR_LAST) begin
        cur_cnt      <= '0;
        cursor_blink <= ~cursor_blink;
      end else begin
        cur_cnt <= cur_cnt + CUR_W'(1);
      end
      if (chr_cnt == CHR_LAST) begin
        chr_cnt    <= '0;
        char_blink <= ~char_blink;
      end else begin
        chr_cnt <= chr_cnt + CHR_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cga_bus_regs.sv
// ---------------------------------------------------------------------------
// tb_cga_bus_regs : directed self-checking bench for cga_bus_regs.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cga_bus_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
  logic        bus_aen, bus_mem_sel;
  logic [7:0]  bus_out;
  logic        bus_dir, bus_rdy;
  logic [4:0]  clk_seq;
  logic        vsync_l, display_enable;
  logic [7:0]  crtc_dout;
  logic        splashscreen;
  logic        crtc_cs, crtc_write, crtc_read;
  logic [7:0]  control_reg, color_reg, page_reg;
  logic        cursor_blink, char_blink;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int base_cnt;

  cga_bus_regs #(
    .IO_BASE_ADDR(16'h3D0), .USE_BUS_WAIT(1'b1),
    .WAIT_START_SLOT(5'd17), .WAIT_END_SLOT(5'd20),
    .CURSOR_FRAMES(8), .CHAR_FRAMES(16), .CTRL_RESET(8'h28)
  ) dut (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_d(bus_d),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
    .bus_aen(bus_aen), .bus_mem_sel(bus_mem_sel),
    .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
    .clk_seq(clk_seq), .vsync_l(vsync_l), .display_enable(display_enable),
    .crtc_dout(crtc_dout), .splashscreen(splashscreen),
    .crtc_cs(crtc_cs), .crtc_write(crtc_write), .crtc_read(crtc_read),
    .control_reg(control_reg), .color_reg(color_reg), .page_reg(page_reg),
    .cursor_blink(cursor_blink), .char_blink(char_blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (crtc_write) wr_seen <= wr_seen + 1;
    if (crtc_read)  rd_seen <= rd_seen + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [14:0] addr, input logic [7:0] data, input int len);
    bus_a = addr;
    bus_d = data;
    bus_iow_l = 1'b0;
    tick(len);
    bus_iow_l = 1'b1;
    tick(4);
  endtask

  task automatic frame();
    vsync_l = 1'b0;
    tick(3);
    vsync_l = 1'b1;
    tick(3);
  endtask

  initial begin
    reset = 1'b1; bus_a = '0; bus_d = '0;
    bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
    bus_aen = 1'b0; bus_mem_sel = 1'b0; clk_seq = '0;
    vsync_l = 1'b1; display_enable = 1'b0; crtc_dout = '0; splashscreen = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_control", control_reg, 8'h28);
    check("rst_color", color_reg, 8'h00);
    check("rst_page", page_reg, 8'h00);
    check("rst_rdy", bus_rdy, 8'h01);
    check("rst_blink", {cursor_blink, char_blink}, 8'h00);
    check("rst_strobes", {crtc_write, crtc_read}, 8'h00);

    // Control write: latency to edge 3, then keep the strobe low 20 cycles.
    bus_a = 15'h3D8; bus_d = 8'h1A; bus_iow_l = 1'b0;
    tick(3);
    check("ctrl_before_edge3", control_reg, 8'h28);
    tick(1);
    check("ctrl_at_edge3", control_reg, 8'h1A);
    tick(16);
    bus_iow_l = 1'b1;
    tick(4);
    check("ctrl_hold", control_reg, 8'h1A);

    io_write(15'h3D9, 8'h0F, 3);
    check("color_write", color_reg, 8'h0F);
    io_write(15'h3DF, 8'h07, 3);
    check("page_write", page_reg, 8'h07);

    // CRTC index/data writes, one strobe each even for a 20-cycle write.
    base_cnt = wr_seen;
    bus_a = 15'h3D4; bus_d = 8'h0E; bus_iow_l = 1'b0;
    tick(1);
    check("crtc_cs_3d4", crtc_cs, 8'h01);
    tick(19);
    bus_iow_l = 1'b1;
    tick(4);
    check("crtc_write_once_3d4", 8'(wr_seen - base_cnt), 8'h01);
    base_cnt = wr_seen;
    io_write(15'h3D5, 8'h22, 3);
    check("crtc_write_once_3d5", 8'(wr_seen - base_cnt), 8'h01);
    check("ctrl_untouched", control_reg, 8'h1A);

    // Inhibited by AEN.
    bus_aen = 1'b1;
    base_cnt = wr_seen;
    io_write(15'h3D9, 8'hFF, 3);
    check("aen_color", color_reg, 8'h0F);
    bus_a = 15'h3D4;
    tick(1);
    check("aen_crtc_cs", crtc_cs, 8'h00);
    check("aen_no_crtc_write", 8'(wr_seen - base_cnt), 8'h00);
    bus_aen = 1'b0;

    // Status reads.
    vsync_l = 1'b0; display_enable = 1'b1;
    tick(3);
    bus_a = 15'h3DA; bus_ior_l = 1'b0;
    #1;
    check("status_vs0_de1", bus_out, 8'hF4);
    check("status_dir", bus_dir, 8'h01);
    bus_ior_l = 1'b1;
    vsync_l = 1'b1; display_enable = 1'b0;
    tick(3);
    bus_ior_l = 1'b0;
    #1;
    check("status_vs1_de0", bus_out, 8'hFD);
    bus_ior_l = 1'b1;
    #1;
    check("status_idle_out", bus_out, 8'h00);
    check("status_idle_dir", bus_dir, 8'h00);

    // CRTC data read, single crtc_read for a long strobe.
    base_cnt = rd_seen;
    crtc_dout = 8'h55; bus_a = 15'h3D5; bus_ior_l = 1'b0;
    #1;
    check("crtc_read_data", bus_out, 8'h55);
    check("crtc_read_dir", bus_dir, 8'h01);
    tick(10);
    bus_ior_l = 1'b1;
    tick(4);
    check("crtc_read_once", 8'(rd_seen - base_cnt), 8'h01);
    bus_a = 15'h3D4; bus_ior_l = 1'b0;
    #1;
    check("crtc_index_read", bus_out, 8'h00);
    bus_a = 15'h3C0;
    #1;
    check("other_dir", bus_dir, 8'h00);
    bus_ior_l = 1'b1;
    tick(4);

    // Wait states: memr starts at slot 5.
    bus_mem_sel = 1'b1; clk_seq = 5'd5; bus_memr_l = 1'b0;
    repeat (3) begin
      tick(1);
      clk_seq = clk_seq + 5'd1;
    end
    check("wait_low_3_edges", bus_rdy, 8'h00);
    while (clk_seq != 5'd20) begin
      tick(1);
      clk_seq = clk_seq + 5'd1;
    end
    check("wait_low_before_20", bus_rdy, 8'h00);
    tick(1);
    check("wait_high_at_20", bus_rdy, 8'h01);
    clk_seq = 5'd3;
    tick(3);
    check("wait_done_hold", bus_rdy, 8'h01);
    bus_memr_l = 1'b1;
    tick(4);

    // Abort during phase A.
    clk_seq = 5'd5; bus_memr_l = 1'b0;
    tick(3);
    clk_seq = 5'd10;
    check("abort_wa_low", bus_rdy, 8'h00);
    bus_memr_l = 1'b1;
    tick(3);
    check("abort_idle_rdy", bus_rdy, 8'h01);
    bus_mem_sel = 1'b0;

    // Blink, from a fresh reset.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst2_control", control_reg, 8'h28);
    for (int i = 0; i < 8; i++) frame();
    check("blink_8", {cursor_blink, char_blink}, 8'h02);
    for (int i = 0; i < 8; i++) frame();
    check("blink_16", {cursor_blink, char_blink}, 8'h01);
    for (int i = 0; i < 8; i++) frame();
    check("blink_24", {cursor_blink, char_blink}, 8'h03);
    for (int i = 0; i < 8; i++) frame();
    check("blink_32", {cursor_blink, char_blink}, 8'h00);
    splashscreen = 1'b1;
    for (int i = 0; i < 10; i++) frame();
    check("splash_hold", {cursor_blink, char_blink}, 8'h00);
    splashscreen = 1'b0;
    for (int i = 0; i < 7; i++) frame();
    check("resume_7", {cursor_blink, char_blink}, 8'h00);
    frame();
    check("resume_8", {cursor_blink, char_blink}, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
